// File: rtl/fifo_pkg.sv
// Shared sizing for the virtual-channel FIFO bank: default widths, per-channel depth and count width.
package fifo_pkg;
   localparam int DATA_SIZE_DEF = 10;
   localparam int ADDR_SIZE_DEF = 3;
   localparam int NUM_CH_DEF    = 2;
   localparam int DEPTH_DEF     = 2 ** ADDR_SIZE_DEF;
   localparam int CNT_W_DEF     = ADDR_SIZE_DEF + 1;

   function automatic int cnt_width(input int addr_size);
      return addr_size + 1;
   endfunction
endpackage

// File: rtl/fifo_vc_channel.sv
// One virtual-channel FIFO: 1-cycle registered pop, flags combinational from count and live thresholds.
// Overflowing pushes are dropped and underflowing pops ignored; both latch a sticky error until reset.
module fifo_vc_channel
   import fifo_pkg::*;
#(
   parameter int DATA_SIZE = DATA_SIZE_DEF,
   parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic [DATA_SIZE-1:0] data_in,
   input  logic                 pop,
   input  logic [ADDR_SIZE:0]   almost_full_in,
   input  logic [ADDR_SIZE:0]   almost_empty_in,
   output logic [DATA_SIZE-1:0] data_out,
   output logic                 valid_out,
   output logic                 empty,
   output logic                 full,
   output logic                 pause,
   output logic                 almost_empty,
   output logic                 error,
   output logic [ADDR_SIZE:0]   occupancy
);
   localparam int CW = cnt_width(ADDR_SIZE);
   localparam int DEPTH = 2 ** ADDR_SIZE;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DATA_SIZE-1:0] mem [DEPTH];
   logic [ADDR_SIZE-1:0] wr_ptr;
   logic [ADDR_SIZE-1:0] rd_ptr;
   logic [CW-1:0]        count;
   logic                 push_ok;
   logic                 pop_ok;
   logic                 overflow;
   logic                 underflow;

   assign empty        = (count == '0);
   assign full         = (count == FULL_CNT);
   assign pause        = (count >= almost_full_in);
   assign almost_empty = (count <= almost_empty_in);
   assign occupancy    = count;

   // A same-cycle pop frees the slot of a full channel, so that push still lands.
   assign pop_ok    = pop && !empty;
   assign push_ok   = push && (!full || pop);
   assign overflow  = push && full && !pop;
   assign underflow = pop && empty;

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         error     <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + ADDR_SIZE'(1);
         if (pop_ok) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + ADDR_SIZE'(1);
         end
         valid_out <= pop_ok;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (overflow || underflow)
            error <= 1'b1;
      end
   end
endmodule

// File: rtl/fifo_vc_bank.sv
// NUM_CH independent VC FIFOs behind one push port; each channel pops with 1-cycle latency.
// Upstream backpressure is the per-channel pause flag; pushes to full or nonexistent channels are dropped.
module fifo_vc_bank
   import fifo_pkg::*;
#(
   parameter int DATA_SIZE = DATA_SIZE_DEF,
   parameter int ADDR_SIZE = ADDR_SIZE_DEF,
   parameter int NUM_CH    = NUM_CH_DEF,
   parameter int CH_SEL    = $clog2(NUM_CH)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          write,
   input  logic [CH_SEL-1:0]             write_ch,
   input  logic [DATA_SIZE-1:0]          data_in_push,
   input  logic [NUM_CH-1:0]             read,
   input  logic [ADDR_SIZE:0]            almost_full_in,
   input  logic [ADDR_SIZE:0]            almost_empty_in,
   output logic [NUM_CH*DATA_SIZE-1:0]   data_out_pop,
   output logic [NUM_CH-1:0]             valid_out,
   output logic [NUM_CH-1:0]             fifo_empty,
   output logic [NUM_CH-1:0]             fifo_full,
   output logic [NUM_CH-1:0]             fifo_pause,
   output logic [NUM_CH-1:0]             fifo_almost_empty,
   output logic [NUM_CH-1:0]             fifo_error,
   output logic [NUM_CH*(ADDR_SIZE+1)-1:0] occupancy
);
   localparam int CW = cnt_width(ADDR_SIZE);

   logic [NUM_CH-1:0] push_vec;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      // An out-of-range write_ch matches no channel, so the push silently vanishes.
      assign push_vec[c] = write && (write_ch == CH_SEL'(c));

      fifo_vc_channel #(
         .DATA_SIZE(DATA_SIZE),
         .ADDR_SIZE(ADDR_SIZE)
      ) u_ch (
         .clk            (clk),
         .reset          (reset),
         .push           (push_vec[c]),
         .data_in        (data_in_push),
         .pop            (read[c]),
         .almost_full_in (almost_full_in),
         .almost_empty_in(almost_empty_in),
         .data_out       (data_out_pop[c*DATA_SIZE +: DATA_SIZE]),
         .valid_out      (valid_out[c]),
         .empty          (fifo_empty[c]),
         .full           (fifo_full[c]),
         .pause          (fifo_pause[c]),
         .almost_empty   (fifo_almost_empty[c]),
         .error          (fifo_error[c]),
         .occupancy      (occupancy[c*CW +: CW])
      );
   end
endmodule
